// File: rtl/sample_pwm_player.sv
// sample_pwm_player: sample FIFO drained by sample_strobe, rendered as single-bit PWM.
// Each strobe pops one sample and restarts a 2**DATA_W clk PWM period.
// If the FIFO is empty at a strobe while playing, MIDSCALE is substituted and underflow pulses.
// Optional macro SAMPLE_PWM_UNDERFLOW_CNT_EN adds the saturating underflow_cnt output.
module sample_pwm_player #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MIDSCALE = 2**(DATA_W-1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_strobe,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     pwm_out,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     underflow,
    output logic                     playing
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]               underflow_cnt
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_STARVED
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   cur_sample_q, cur_sample_d;
    logic [DATA_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                pwm_out_q, pwm_out_d;
    logic                underflow_q, underflow_d;

    logic                full;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   head;
    logic [DATA_W-1:0]   pwm_cnt_inc;

    // FIFO bookkeeping: ready and the pop decision use only registered fill,
    // so a same-edge push into an empty FIFO is invisible to the strobe.
    always_comb begin
        full     = (fill_q == FULL_LVL);
        push     = wr_valid && !full;
        pop      = sample_strobe && (fill_q != '0);
        head     = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
    end

    // Playback FSM and PWM generator; period restarts on every strobe outside IDLE.
    always_comb begin
        state_d      = state_q;
        cur_sample_d = cur_sample_q;
        pwm_cnt_d    = pwm_cnt_q;
        pwm_out_d    = pwm_out_q;
        underflow_d  = 1'b0;
        pwm_cnt_inc  = pwm_cnt_q + DATA_W'(1);
        case (state_q)
            ST_IDLE: begin
                pwm_cnt_d = '0;
                pwm_out_d = 1'b0;
                if (pop) begin
                    state_d      = ST_PLAY;
                    cur_sample_d = head;
                    pwm_out_d    = (head != '0);
                end
            end
            default: begin
                if (sample_strobe) begin
                    if (pop) begin
                        state_d      = ST_PLAY;
                        cur_sample_d = head;
                    end else begin
                        state_d      = ST_STARVED;
                        cur_sample_d = DATA_W'(MIDSCALE);
                        underflow_d  = 1'b1;
                    end
                    pwm_cnt_d = '0;
                    pwm_out_d = (cur_sample_d != '0);
                end else begin
                    pwm_cnt_d = pwm_cnt_inc;
                    pwm_out_d = (pwm_cnt_inc < cur_sample_q);
                end
            end
        endcase
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            cur_sample_q <= '0;
            pwm_cnt_q    <= '0;
            pwm_out_q    <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            cur_sample_q <= cur_sample_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_out_q    <= pwm_out_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    // Saturating tally of underflow pulses, counted on the edge that raises the pulse.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underflow_d && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end
    end

    // Underflow counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

    assign wr_ready  = !full;
    assign pwm_out   = pwm_out_q;
    assign fill      = fill_q;
    assign underflow = underflow_q;
    assign playing   = (state_q == ST_PLAY);

endmodule

// File: tb/tb_sample_pwm_player.sv
// Directed bench for sample_pwm_player (DATA_W=8, DEPTH=4, MIDSCALE=128).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sample_pwm_player;

    logic       clk;
    logic       rst;
    logic       sample_strobe;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       pwm_out;
    logic [2:0] fill;
    logic       underflow;
    logic       playing;
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
    logic [7:0] underflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sample_pwm_player #(
        .DATA_W   (8),
        .DEPTH    (4),
        .MIDSCALE (128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .pwm_out       (pwm_out),
        .fill          (fill),
        .underflow     (underflow),
        .playing       (playing)
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the falling edge right after the strobe edge.
    task automatic do_strobe();
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    // Push one sample; returns at the falling edge after the push edge.
    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Observe 256 cycles starting at the current falling edge (the one just
    // after a strobe). Expected shape: high while index < s, low afterwards.
    task automatic watch_period(input string tag, input int s, input int exp_uf);
        int hi  = 0;
        int bad = 0;
        int uf  = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm_out === 1'b1) hi++;
            if (pwm_out !== ((i < s) ? 1'b1 : 1'b0)) bad++;
            if (underflow === 1'b1) uf++;
        end
        check({tag, "_high_cnt"}, hi, s);
        check({tag, "_shape_err"}, bad, 0);
        check({tag, "_uf_pulses"}, uf, exp_uf);
    endtask

    initial begin
        rst           = 1'b1;
        sample_strobe = 1'b0;
        wr_valid      = 1'b0;
        wr_data       = '0;

        // Reset for two clocks.
        @(negedge clk);
        @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_fill", fill, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_playing", playing, 0);
        check("rst_uf", underflow, 0);
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
        check("rst_ucnt", underflow_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Strobes while idle and empty: no playback, no underflow.
        for (int k = 0; k < 3; k++) begin
            do_strobe();
            check("idle_uf", underflow, 0);
            check("idle_playing", playing, 0);
            check("idle_pwm", pwm_out, 0);
            repeat (3) @(negedge clk);
        end

        // Single sample 0x40: 64 high, 192 low.
        push(8'h40);
        check("p40_fill1", fill, 1);
        do_strobe();
        check("p40_playing", playing, 1);
        check("p40_fill0", fill, 0);
        watch_period("p40", 64, 0);

        // Boundary samples 0x00 and 0xFF.
        push(8'h00);
        push(8'hFF);
        check("bnd_fill2", fill, 2);
        do_strobe();
        check("bnd_fill1", fill, 1);
        watch_period("s00", 0, 0);
        do_strobe();
        check("bnd_fill0", fill, 0);
        watch_period("sff", 255, 0);

        // Underflow while playing: midscale substituted, one-cycle pulse.
        do_strobe();
        check("uf_pulse", underflow, 1);
        check("uf_playing", playing, 0);
        watch_period("mid", 128, 1);
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
        check("uf_ucnt", underflow_cnt, 1);
`endif
        push(8'h10);
        do_strobe();
        check("rec_playing", playing, 1);
        check("rec_uf", underflow, 0);
        watch_period("s10", 16, 0);

        // Fill to capacity, then hold a fifth sample.
        push(8'h20);
        push(8'h30);
        push(8'h50);
        push(8'h60);
        wr_valid = 1'b1;
        wr_data  = 8'h70;
        @(negedge clk);
        check("full_fill", fill, 4);
        check("full_ready", wr_ready, 0);
        @(negedge clk);
        check("full_hold_fill", fill, 4);
        // Strobe while full with wr_valid held: pop only on that edge.
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        check("fs_fill3", fill, 3);
        check("fs_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        check("fs_fill4", fill, 4);
        check("fs_ready0", wr_ready, 0);

        // FIFO order: 0x20 was popped, next is 0x30.
        do_strobe();
        check("ord_fill", fill, 3);
        watch_period("s30", 48, 0);

        // Reset in mid-period with two samples buffered and pwm_out high.
        do_strobe();
        repeat (10) @(negedge clk);
        check("mr_pre_pwm", pwm_out, 1);
        check("mr_pre_fill", fill, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_pwm", pwm_out, 0);
        check("mr_fill", fill, 0);
        check("mr_playing", playing, 0);
        check("mr_ready", wr_ready, 1);
`ifdef SAMPLE_PWM_UNDERFLOW_CNT_EN
        check("mr_ucnt", underflow_cnt, 0);
`endif
        do_strobe();
        check("mr_strobe_playing", playing, 0);
        watch_period("mr_idle", 0, 0);

        // Push into empty FIFO on the strobe edge: strobe sees empty.
        wr_valid      = 1'b1;
        wr_data       = 8'h08;
        sample_strobe = 1'b1;
        @(negedge clk);
        wr_valid      = 1'b0;
        sample_strobe = 1'b0;
        check("same_edge_playing", playing, 0);
        check("same_edge_fill", fill, 1);
        do_strobe();
        check("same_edge_next_playing", playing, 1);
        watch_period("s08", 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
